mem_arbiter: RTL and testbench

- Arbitrates the single shared unified main memory between instruction-cache miss fills and data-cache miss fills and stores.
- Sequences each 16-byte block fill as 8 back-to-back word reads to the pipelined multi-cycle memory, and returns the words to the requesting cache.
- Sits between the IF-stage and MEM-stage cache controllers and the memory model.

---
 rtl/mem_arbiter.sv | 99 +++++++++
 tb/tb_mem_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between I-cache fills and D-cache fills/stores.
// MEM_ARB_RR_EN selects round-robin arbitration instead of data-first priority.
module mem_arbiter #(
   parameter int LATENCY = 4,
   parameter int WORDS   = 8,
   parameter int AW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_grant,
   output logic          i_valid,
   output logic          i_done,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [15:0]   d_wdata,
   output logic          d_grant,
   output logic          d_valid,
   output logic          d_done,
   output logic [15:0]   fill_data,
   output logic [2:0]    fill_idx,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   input  logic [15:0]   mem_rdata,
   input  logic          mem_valid
);
   typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;
   state_t        r_state;
   logic [AW-1:0] r_addr;
   logic [15:0]   r_wdata;
   logic [2:0]    r_k;
   logic [2:0]    r_rcv;
   logic          r_issued;
   logic          w_fill, w_issue, w_rv, w_last, w_wr, w_pick_d;
   logic          w_unused;
   assign w_unused = &{1'b0, i_addr[3:0], d_addr[0], LATENCY > 0};
   assign w_fill   = (r_state == I_FILL) || (r_state == D_FILL);
   assign w_issue  = w_fill && !r_issued;
   assign w_rv     = w_fill && mem_valid;
   assign w_last   = w_rv && (r_rcv == 3'(WORDS - 1));
   assign w_wr     = r_state == D_WRITE;
`ifdef MEM_ARB_RR_EN
   logic r_last;
   // r_last: 0 = instruction side granted most recently, 1 = data side
   assign w_pick_d = d_req && (!i_req || !r_last);
   always_ff @(posedge clk)
      if (rst) r_last <= 1'b0;
      else if (r_state == IDLE && (d_req || i_req)) r_last <= w_pick_d;
`else
   assign w_pick_d = d_req;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_k      <= '0;
         r_rcv    <= '0;
         r_issued <= 1'b0;
      end else if (r_state == IDLE) begin
         r_k      <= '0;
         r_rcv    <= '0;
         r_issued <= 1'b0;
         if (w_pick_d) begin
            r_state <= d_we ? D_WRITE : D_FILL;
            r_addr  <= d_we ? {d_addr[AW-1:1], 1'b0} : {d_addr[AW-1:4], 4'b0};
            r_wdata <= d_wdata;
         end else if (i_req) begin
            r_state <= I_FILL;
            r_addr  <= {i_addr[AW-1:4], 4'b0};
         end
      end else if (w_wr) begin
         r_state <= IDLE;
      end else begin
         if (w_issue) begin
            r_k      <= r_k + 3'd1;
            r_issued <= r_k == 3'(WORDS - 1);
         end
         if (w_rv) r_rcv <= r_rcv + 3'd1;
         if (w_last) r_state <= IDLE;
      end
   end
   assign i_grant   = r_state == I_FILL;
   assign d_grant   = (r_state == D_FILL) || w_wr;
   assign i_valid   = w_rv && (r_state == I_FILL);
   assign d_valid   = w_rv && (r_state == D_FILL);
   assign i_done    = w_last && (r_state == I_FILL);
   assign d_done    = (w_last && (r_state == D_FILL)) || w_wr;
   assign fill_data = w_rv ? mem_rdata : 16'h0;
   assign fill_idx  = w_rv ? r_rcv : 3'd0;
   assign mem_en    = w_issue || w_wr;
   assign mem_wr    = w_wr;
   assign mem_addr  = w_wr ? r_addr : w_issue ? r_addr + AW'({r_k, 1'b0}) : '0;
   assign mem_wdata = w_wr ? r_wdata : 16'h0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a 4-cycle pipelined memory model.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic        i_grant, i_valid, i_done, d_grant, d_valid, d_done;
   logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  fill_idx;
   logic        mem_en, mem_wr, mem_valid;
   logic        spur = 1'b0;
   logic [3:0]  pv;
   logic [15:0] pd [4];
   int          n_chk = 0, n_bad = 0;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_valid(i_valid), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_grant(d_grant), .d_valid(d_valid), .d_done(d_done),
      .fill_data(fill_data), .fill_idx(fill_idx),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid)
   );

   always #5 clk = ~clk;

   // memory returns 0xA000 + word index of the issued address, 4 cycles after issue
   always @(posedge clk) begin
      if (rst) pv <= '0;
      else pv <= {pv[2:0], mem_en & ~mem_wr};
      pd[0] <= 16'hA000 + {13'b0, mem_addr[3:1]};
      for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
   end
   assign mem_valid = pv[3] | spur;
   assign mem_rdata = pd[3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_check(input bit is_d, input logic [15:0] base, input int drop);
      step();
      for (int c = 1; c <= 12; c++) begin
         automatic bit iss = c <= 8;
         automatic bit v = c >= 5;
         check("grant", is_d ? d_grant : i_grant, 1);
         check("other_grant", is_d ? i_grant : d_grant, 0);
         check("mem_en", mem_en, iss);
         check("mem_wr", mem_wr, 0);
         check("mem_wdata", mem_wdata, 0);
         check("mem_addr", mem_addr, iss ? base + 2 * (c - 1) : 0);
         check("valid", is_d ? d_valid : i_valid, v);
         check("other_valid", is_d ? i_valid : d_valid, 0);
         check("fill_idx", fill_idx, v ? c - 5 : 0);
         check("fill_data", fill_data, v ? 16'hA000 + c - 5 : 0);
         check("done", is_d ? d_done : i_done, c == 12);
         check("other_done", is_d ? i_done : d_done, 0);
         if (c == drop) begin
            if (is_d) d_req = 1'b0;
            else i_req = 1'b0;
         end
         step();
      end
      check("grant_fall", {i_grant, d_grant}, 0);
      if (is_d) d_req = 1'b0;
      else i_req = 1'b0;
   endtask

   initial begin
      step();
      step();
      check("rst_grant", {i_grant, d_grant}, 0);
      check("rst_valid", {i_valid, d_valid, i_done, d_done}, 0);
      check("rst_mem", {mem_en, mem_wr}, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_fill", {fill_data, fill_idx}, 0);
      rst = 1'b0;
      step();
      i_req = 1'b1;
      i_addr = 16'h0126;
      fill_check(0, 16'h0120, 0);

      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h2005; d_wdata = 16'hBEEF;
      step();
      check("st_grant", d_grant, 1);
      check("st_en_wr", {mem_en, mem_wr}, 2'b11);
      check("st_addr", mem_addr, 16'h2004);
      check("st_wdata", mem_wdata, 16'hBEEF);
      check("st_done", d_done, 1);
      check("st_ifree", {i_grant, i_done}, 0);
      d_req = 1'b0; d_we = 1'b0;
      step();
      check("st_after", {d_grant, mem_en, mem_wr, d_done}, 0);
      check("st_wdata0", mem_wdata, 0);

      i_req = 1'b1; i_addr = 16'h0300;
      d_req = 1'b1; d_addr = 16'h4000;
`ifdef MEM_ARB_RR_EN
      fill_check(0, 16'h0300, 0);
      fill_check(1, 16'h4000, 0);
`else
      fill_check(1, 16'h4000, 0);
      fill_check(0, 16'h0300, 0);
`endif

      i_req = 1'b1; i_addr = 16'h0500;
      for (int c = 1; c <= 5; c++) begin
         step();
         check("mr_addr", mem_addr, 16'h0500 + 2 * (c - 1));
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mr_grant", {i_grant, d_grant}, 0);
      check("mr_outs", {i_valid, d_valid, i_done, d_done, mem_en, mem_wr}, 0);
      check("mr_addr0", mem_addr, 0);
      check("mr_fill", {fill_data, fill_idx}, 0);
      fill_check(0, 16'h0500, 0);

      spur = 1'b1;
      #1;
      check("sp_valid", {i_valid, d_valid, i_done, d_done}, 0);
      check("sp_fill", {fill_data, fill_idx}, 0);
      step();
      spur = 1'b0;
      check("sp_idle", {i_grant, d_grant}, 0);
      i_req = 1'b1; i_addr = 16'h0708;
      fill_check(0, 16'h0700, 3);
      step();
      check("end_idle", {i_grant, d_grant, mem_en}, 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
